// File: rtl/video_scan_fetch.sv
// Framebuffer scan-out fetch: turns sync-generator timing into read requests with
// 1x/2x/4x pixel replication and returns a pixel-aligned index stream with delayed sync.
module video_scan_fetch #(
  parameter int HCW        = 12,
  parameter int VCW        = 12,
  parameter int AW         = 19,
  parameter int DW         = 8,
  parameter int RL         = 2,
  parameter int DEF_W      = 800,
  parameter int DEF_H      = 600,
  parameter int DEF_STRIDE = 800
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clk_en,
  input  logic           en,
  input  logic           cfg_upd,
  output logic           cfg_busy,
  input  logic [1:0]     cfg_scale_x,
  input  logic [1:0]     cfg_scale_y,
  input  logic [HCW-1:0] cfg_src_w,
  input  logic [VCW-1:0] cfg_src_h,
  input  logic [AW-1:0]  cfg_base,
  input  logic [AW-1:0]  cfg_stride,
  input  logic           s_active,
  input  logic           s_hsync,
  input  logic           s_vsync,
  input  logic           s_a_start,
  input  logic           s_a_end,
  output logic           mem_rd,
  output logic [AW-1:0]  mem_adr,
  input  logic [DW-1:0]  mem_dat,
  output logic           vid_active,
  output logic           vid_hsync,
  output logic           vid_vsync,
  output logic           vid_valid,
  output logic [DW-1:0]  vid_idx
);

  function automatic logic [1:0] scale_last(input logic [1:0] s);
    case (s)
      2'd0:    return 2'd0;
      2'd1:    return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  logic           pending;
  logic [1:0]     sh_sx, sh_sy;
  logic [HCW-1:0] sh_w;
  logic [VCW-1:0] sh_h;
  logic [AW-1:0]  sh_base, sh_stride;

  logic           en_frame, act_q;
  logic [AW-1:0]  line_base;
  logic [HCW-1:0] x_src;
  logic [VCW-1:0] y_src;
  logic [1:0]     x_sub, y_sub;

  logic [RL:0]      v_pipe;
  logic [RL:0][2:0] sync_d;

  logic           apply, en_eff, in_src, fetch;
  logic [AW-1:0]  lb_eff, lb_n;
  logic [HCW-1:0] xs_eff, xs_n;
  logic [VCW-1:0] ys_eff, ys_n;
  logic [1:0]     xsub_eff, xsub_n, ysub_eff, ysub_n;

  assign cfg_busy = pending;
  assign mem_rd   = v_pipe[0];

  // The s_a_start pixel is fetched from the cleared frame state, so the start
  // cycle substitutes reset values for the counters before they are registered.
  always_comb begin
    apply    = (pending && (s_a_end || !en_frame)) || (cfg_upd && s_a_end);
    en_eff   = s_a_start ? en      : en_frame;
    lb_eff   = s_a_start ? sh_base : line_base;
    xs_eff   = s_a_start ? '0      : x_src;
    xsub_eff = s_a_start ? '0      : x_sub;
    ys_eff   = s_a_start ? '0      : y_src;
    ysub_eff = s_a_start ? '0      : y_sub;
    in_src   = (xs_eff < sh_w) && (ys_eff < sh_h);
    fetch    = s_active && en_eff;

    xs_n   = xs_eff;
    xsub_n = xsub_eff;
    ys_n   = ys_eff;
    ysub_n = ysub_eff;
    lb_n   = lb_eff;
    if (s_active) begin
      if (xsub_eff == scale_last(sh_sx)) begin
        xsub_n = '0;
        if (xs_eff < sh_w) xs_n = xs_eff + HCW'(1);
      end else begin
        xsub_n = xsub_eff + 2'd1;
      end
    end else if (act_q) begin
      xs_n   = '0;
      xsub_n = '0;
      if (ysub_eff == scale_last(sh_sy)) begin
        ysub_n = '0;
        if (ys_eff < sh_h) ys_n = ys_eff + VCW'(1);
        lb_n = lb_eff + sh_stride;
      end else begin
        ysub_n = ysub_eff + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending    <= 1'b0;
      sh_sx      <= '0;
      sh_sy      <= '0;
      sh_w       <= HCW'(DEF_W);
      sh_h       <= VCW'(DEF_H);
      sh_base    <= '0;
      sh_stride  <= AW'(DEF_STRIDE);
      en_frame   <= 1'b0;
      act_q      <= 1'b0;
      line_base  <= '0;
      x_src      <= '0;
      x_sub      <= '0;
      y_src      <= '0;
      y_sub      <= '0;
      v_pipe     <= '0;
      mem_adr    <= '0;
      sync_d     <= '0;
      vid_active <= 1'b0;
      vid_hsync  <= 1'b0;
      vid_vsync  <= 1'b0;
      vid_valid  <= 1'b0;
      vid_idx    <= '0;
    end else if (clk_en) begin
      if (apply) begin
        pending   <= 1'b0;
        sh_sx     <= cfg_scale_x;
        sh_sy     <= cfg_scale_y;
        sh_w      <= cfg_src_w;
        sh_h      <= cfg_src_h;
        sh_base   <= cfg_base;
        sh_stride <= cfg_stride;
      end else if (cfg_upd) begin
        pending <= 1'b1;
      end
      if (s_a_start) en_frame <= en;
      act_q     <= s_active;
      line_base <= lb_n;
      x_src     <= xs_n;
      x_sub     <= xsub_n;
      y_src     <= ys_n;
      y_sub     <= ysub_n;
      v_pipe    <= {v_pipe[RL-1:0], fetch && in_src};
      if (fetch) mem_adr <= lb_eff + AW'(xs_eff);
      sync_d    <= {sync_d[RL-1:0], {s_active, s_hsync, s_vsync}};
      {vid_active, vid_hsync, vid_vsync} <= sync_d[RL];
      vid_valid <= v_pipe[RL];
      vid_idx   <= v_pipe[RL] ? mem_dat : '0;
    end
  end

endmodule

// File: doc/video_scan_fetch.md
Name: video_scan_fetch

Overview:
- Parametrised successor to the fixed 800x600 scan-out: converts sync-generator timing into framebuffer read requests and returns a pixel-aligned index stream with matching delayed sync.
- Adds runtime-configurable source size, base, stride and integer pixel replication (1x/2x/4x per axis), frame-synchronous shadowed configuration, and a parametrised memory read latency.
- Sits between video_sync_gen and the CLUT/mixer stages; framebuffer memory is external and shares clk/clk_en.

Parameters:
HCW, 12, horizontal counter / source width bits
VCW, 12, vertical counter / source height bits
AW, 19, framebuffer address width
DW, 8, index data width
RL, 2, memory read latency in clk_en cycles (legal 1..8)
DEF_W, 800, reset source width
DEF_H, 600, reset source height
DEF_STRIDE, 800, reset line stride

Ports:
clk  in  1  video clock
rst  in  1  synchronous active-high reset
clk_en  in  1  clock enable; all state advances only when high
en  in  1  fetch enable, sampled at frame start
cfg_upd  in  1  pulse: request shadow-config update
cfg_busy  out  1  update pending, not yet applied
cfg_scale_x  in  2  0=1x, 1=2x, 2=4x, 3=4x
cfg_scale_y  in  2  same encoding, vertical
cfg_src_w  in  HCW  source width in source pixels
cfg_src_h  in  VCW  source height in source lines
cfg_base  in  AW  framebuffer base address
cfg_stride  in  AW  address increment per source line
s_active  in  1  sync-gen active
s_hsync  in  1  sync-gen hsync
s_vsync  in  1  sync-gen vsync
s_a_start  in  1  first active pixel of frame
s_a_end  in  1  last active pixel of frame
mem_rd  out  1  read request
mem_adr  out  AW  read address
mem_dat  in  DW  read data, valid RL cycles after mem_rd
vid_active  out  1  delayed s_active
vid_hsync  out  1  delayed s_hsync
vid_vsync  out  1  delayed s_vsync
vid_valid  out  1  pixel inside source image
vid_idx  out  DW  pixel index, 0 when vid_valid=0

Behaviour:
- Reset: all outputs 0; pipeline cleared; shadow config = scale 1x/1x, DEF_W, DEF_H, base 0, DEF_STRIDE; cfg_busy 0; fetch counters 0; en_frame 0.
- clk_en low: every register holds, including mem_rd/mem_adr.
- Shadow config: cfg_upd sets pending (cfg_busy=1). Copy cfg_* to shadow on the cycle where pending and s_a_end are both high, then clear pending. If cfg_upd and s_a_end coincide, apply on that cycle with cfg_busy never rising. cfg_* are sampled only on the apply cycle. If en_frame=0, apply pending on the next clk_en cycle regardless of s_a_end.
- Frame start (s_a_start): en_frame<=en; line_base<=base; x_src, x_sub, y_src, y_sub <=0. The s_a_start pixel itself is fetched with these cleared values.
- Per active pixel (s_active=1, en_frame=1):
  - in_src = (x_src<src_w) && (y_src<src_h).
  - Next cycle: mem_rd<=in_src; mem_adr<=line_base+x_src, modulo 2^AW.
  - x_sub increments; when x_sub==fx-1, x_sub<=0 and x_src++ (fx=1,2,4). x_src saturates at src_w.
- End of line (s_active falling): x_src, x_sub <=0. y_sub++; when y_sub==fy-1, y_sub<=0, y_src++ (saturating at src_h), line_base<=line_base+stride.
- Blanking or en_frame=0: mem_rd<=0; mem_adr holds.
- Latency:
  - Input pixel at cycle t gives mem_rd at t+1 and mem_dat at t+1+RL.
  - vid_idx/vid_valid are registered at t+2+RL.
  - All vid_* sync outputs are delayed exactly RL+2 cycles.
  - vid_valid is in_src delayed; vid_idx=mem_dat when valid, else 0.
- Boundaries:
  - src_w=0 or src_h=0: no reads, vid_valid=0 all frame.
  - src_w above active width: the line truncates and the next line restarts at x_src=0.
  - en dropping mid-frame: the current frame completes; takes effect at the next s_a_start.
  - s_a_start without a preceding s_a_end (e.g. after reset): counters are still cleared.

Test Plan:
- Reset mid-frame, then 16x8 active timing, RL=2, 1x, src 16x8, base 0, stride 16 -> first mem_adr 0 one cycle after s_a_start; line 1 starts 16; last 127; vid_* = sync delayed 4 cycles; vid_idx follows mem_dat.
- Scale 2x/2x, src 8x4, stride 8, base 0x100 -> addresses 0x100,0x100,0x101,0x101,...; lines 0 and 1 identical; line 2 starts 0x108.
- src_w=10 on 16-wide active -> mem_rd high for 10 cycles per line; vid_valid low and vid_idx 0 for pixels 10..15; src_h=5 -> lines 5..7 invalid with no reads.
- cfg_upd mid-frame with base 0x200 -> cfg_busy=1 until s_a_end; current frame keeps base 0; next frame's first address 0x200. cfg_upd coincident with s_a_end -> applied, cfg_busy stays 0.
- Base 0x7FFF8, stride 16, AW=19 -> address wraps 0x7FFFF to 0x00000 with no gap.
- en low at frame start with clk_en toggling 1-of-2 -> no mem_rd that frame; sync passes with latency RL+2 enabled cycles; all state holds while clk_en=0.
